// File: rtl/sp_matrix_ls_resp.sv
// -----------------------------------------------------------------------------
// sp_matrix_ls_resp
//
// Purpose:
//   Sequences one matrix load or store between the matrix register file and
//   the scratchpad. An accepted request moves ROWS rows, one ROW_W-bit beat
//   per row. The first row's address is rs + sign-extended imm. Each
//   following row adds stride. Loads write each returned beat into the
//   register file. Stores read each row combinationally and drive it out as
//   write data. When the last beat is done, mhit pulses for one cycle.
//
// Optional feature (macro SP_LS_ALIGN_ERR_EN):
//   defined   : a base or stride that is not 8-byte aligned makes the request
//               complete at once with err=1, and no memory beats are issued.
//   undefined : mem_addr[2:0] is forced to 0 and err is tied low.
//
// Ports:
//   CLK, RST            single clock, asynchronous active-high reset
//   req_valid/req_ready request handshake; ready only while idle
//   req_ls              2'b01 load, 2'b10 store; other codes are accepted and dropped
//   req_rd              matrix register number
//   req_rs/req_imm      base address and signed 11-bit offset
//   req_stride          byte distance between consecutive rows
//   mem_req/mem_ack     beat handshake; ack may arrive in the cycle req rises
//   mem_wen/mem_addr    beat direction and address
//   mem_wdata/mem_rdata beat data
//   rf_wen/rf_waddr/rf_row/rf_wdata   register-file row write (loads)
//   st_raddr/st_row/st_rdata          register-file row read (stores)
//   mhit                one-cycle completion pulse
//   err                 alignment error, valid together with mhit
//   busy                high while a request is in flight
// -----------------------------------------------------------------------------
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a request
// S_XFER | issuing row beats, waiting on mem_ack for each
// S_DONE | completion cycle: mhit (and err when misaligned)
// -----------------------------------------------------------------------------
module sp_matrix_ls_resp #(
    parameter int ROWS  = 4,
    parameter int ROW_W = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    input  logic [1:0]              req_ls,
    input  logic [4:0]              req_rd,
    input  logic [31:0]             req_rs,
    input  logic [31:0]             req_stride,
    input  logic [10:0]             req_imm,
    output logic                    req_ready,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [31:0]             mem_addr,
    output logic [ROW_W-1:0]        mem_wdata,
    input  logic [ROW_W-1:0]        mem_rdata,
    input  logic                    mem_ack,
    output logic                    rf_wen,
    output logic [4:0]              rf_waddr,
    output logic [$clog2(ROWS)-1:0] rf_row,
    output logic [ROW_W-1:0]        rf_wdata,
    output logic [4:0]              st_raddr,
    output logic [$clog2(ROWS)-1:0] st_row,
    input  logic [ROW_W-1:0]        st_rdata,
    output logic                    mhit,
    output logic                    err,
    output logic                    busy
);

    localparam int         RW       = $clog2(ROWS);
    localparam logic [1:0] LS_LOAD  = 2'b01;
    localparam logic [1:0] LS_STORE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [4:0]    rd_q, rd_d;
    logic          is_store_q, is_store_d;
    logic [31:0]   stride_q, stride_d;
    // Address of the current row. It moves forward by stride on every acked
    // beat, so no row*stride multiply is needed.
    logic [31:0]   addr_q, addr_d;
`ifdef SP_LS_ALIGN_ERR_EN
    logic          err_q, err_d;
`endif

    logic [31:0] base_calc;
    logic        ls_valid;
    logic        misaligned;
    logic        last_row;

    assign base_calc = req_rs + {{21{req_imm[10]}}, req_imm};
    assign ls_valid  = (req_ls == LS_LOAD) || (req_ls == LS_STORE);
    assign last_row  = (row_q == RW'(ROWS - 1));

`ifdef SP_LS_ALIGN_ERR_EN
    assign misaligned = (base_calc[2:0] != 3'b000) || (req_stride[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rd_d       = rd_q;
        is_store_d = is_store_q;
        stride_d   = stride_q;
        addr_d     = addr_q;
`ifdef SP_LS_ALIGN_ERR_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // A request with an invalid ls code is consumed here and
                // dropped: the FSM stays idle.
                if (req_valid && ls_valid) begin
                    rd_d       = req_rd;
                    is_store_d = (req_ls == LS_STORE);
                    stride_d   = req_stride;
                    addr_d     = base_calc;
                    row_d      = '0;
`ifdef SP_LS_ALIGN_ERR_EN
                    err_d      = misaligned;
`endif
                    state_d    = misaligned ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    addr_d = addr_q + stride_q;
                    row_d  = row_q + RW'(1);
                    if (last_row) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            stride_q   <= '0;
            addr_q     <= '0;
`ifdef SP_LS_ALIGN_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rd_q       <= rd_d;
            is_store_q <= is_store_d;
            stride_q   <= stride_d;
            addr_q     <= addr_d;
`ifdef SP_LS_ALIGN_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Every output is decoded from registered state plus live inputs. This
    // means reset forces the idle values at once, and address, direction
    // and write data stay constant across mem_ack wait cycles.
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign mem_req   = (state_q == S_XFER);
    assign mem_wen   = mem_req && is_store_q;

`ifdef SP_LS_ALIGN_ERR_EN
    assign mem_addr  = mem_req ? addr_q : 32'h0;
`else
    // Misaligned requests are not flagged, so the beat address is
    // rounded down to the 8-byte row boundary.
    assign mem_addr  = mem_req ? {addr_q[31:3], 3'b000} : 32'h0;
`endif

    assign mem_wdata = mem_wen ? st_rdata : '0;
    assign st_raddr  = rd_q;
    assign st_row    = row_q;

    // mem_ack is only meaningful in S_XFER, where mem_req is high.
    assign rf_wen    = mem_req && !is_store_q && mem_ack;
    assign rf_waddr  = rd_q;
    assign rf_row    = row_q;
    assign rf_wdata  = rf_wen ? mem_rdata : '0;

    assign mhit      = (state_q == S_DONE);
`ifdef SP_LS_ALIGN_ERR_EN
    assign err       = (state_q == S_DONE) && err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sp_matrix_ls_resp.sv
`timescale 1ns/1ps
module tb_sp_matrix_ls_resp;

    localparam int ROWS  = 4;
    localparam int ROW_W = 64;
    localparam int RW    = $clog2(ROWS);

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              req_valid;
    logic [1:0]        req_ls;
    logic [4:0]        req_rd;
    logic [31:0]       req_rs;
    logic [31:0]       req_stride;
    logic [10:0]       req_imm;
    logic              req_ready;
    logic              mem_req;
    logic              mem_wen;
    logic [31:0]       mem_addr;
    logic [ROW_W-1:0]  mem_wdata;
    logic [ROW_W-1:0]  mem_rdata;
    logic              mem_ack;
    logic              rf_wen;
    logic [4:0]        rf_waddr;
    logic [RW-1:0]     rf_row;
    logic [ROW_W-1:0]  rf_wdata;
    logic [4:0]        st_raddr;
    logic [RW-1:0]     st_row;
    logic [ROW_W-1:0]  st_rdata;
    logic              mhit;
    logic              err;
    logic              busy;

    sp_matrix_ls_resp #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ls(req_ls), .req_rd(req_rd), .req_rs(req_rs),
        .req_stride(req_stride), .req_imm(req_imm), .req_ready(req_ready),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_row(rf_row), .rf_wdata(rf_wdata),
        .st_raddr(st_raddr), .st_row(st_row), .st_rdata(st_rdata),
        .mhit(mhit), .err(err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Register-file contents that stores read from.
    logic [ROW_W-1:0] rfm [32][ROWS];
    assign st_rdata = rfm[st_raddr][st_row];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level reference model.
    bit          m_active, m_done, m_err, m_store, idle;
    int          m_beat, m_waits, m_acc;
    logic [31:0] m_base, m_stride;
    logic [4:0]  m_rd;

    // Observation logs for the directed literal checks.
    logic [31:0] addr_log[$];
    int          row_log[$];
    int          acc_cnt, mhit_cnt, rfw_cnt, err_cnt, memreq_cnt;
    int          last_acc, last_mhit;

    int fixed_wait;
    int wait_left;

    function automatic logic [31:0] beat_addr(input logic [31:0] b, input logic [31:0] s, input int k);
        logic [31:0] a;
        a = b + s * 32'(k);
`ifndef SP_LS_ALIGN_ERR_EN
        a[2:0] = 3'b000;
`endif
        return a;
    endfunction

    // Checker and model update, once per cycle, away from the active edge.
    initial begin
        m_active = 0; m_done = 0; m_err = 0; m_store = 0;
        m_beat = 0; m_waits = 0; m_acc = 0;
        acc_cnt = 0; mhit_cnt = 0; rfw_cnt = 0; err_cnt = 0; memreq_cnt = 0;
        last_acc = 0; last_mhit = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rst_req_ready", req_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_wen", mem_wen, 0);
                chk("rst_rf_wen", rf_wen, 0);
                chk("rst_mhit", mhit, 0);
                chk("rst_err", err, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_rf_waddr", rf_waddr, 0);
                chk("rst_rf_row", rf_row, 0);
                chk("rst_rf_wdata", rf_wdata, 0);
                m_active = 0; m_done = 0; m_err = 0;
            end else begin
                idle = !m_active && !m_done;
                chk("req_ready", req_ready, idle);
                chk("busy", busy, !idle);
                chk("mhit", mhit, m_done);
                chk("err", err, m_done && m_err);
                chk("mem_req", mem_req, m_active);
                if (m_active) begin
                    chk("mem_addr", mem_addr, beat_addr(m_base, m_stride, m_beat));
                    chk("mem_wen", mem_wen, m_store);
                    if (m_store) begin
                        chk("mem_wdata", mem_wdata, rfm[m_rd][m_beat]);
                        chk("st_raddr", st_raddr, m_rd);
                        chk("st_row", st_row, m_beat);
                    end
                    chk("rf_wen", rf_wen, !m_store && mem_ack);
                    if (!m_store && mem_ack) begin
                        chk("rf_waddr", rf_waddr, m_rd);
                        chk("rf_row", rf_row, m_beat);
                        chk("rf_wdata", rf_wdata, mem_rdata);
                    end
                end else begin
                    chk("mem_wen_idle", mem_wen, 0);
                    chk("rf_wen_idle", rf_wen, 0);
                end
                if (mhit)
                    chk("latency", cyc - m_acc, m_err ? 1 : ROWS + 1 + m_waits);

                if (mem_req && mem_ack) begin
                    addr_log.push_back(mem_addr);
                    row_log.push_back(int'(st_row));
                end
                if (req_valid && req_ready) begin acc_cnt++; last_acc = cyc; end
                if (mhit) begin mhit_cnt++; last_mhit = cyc; if (err) err_cnt++; end
                if (rf_wen) rfw_cnt++;
                if (mem_req) memreq_cnt++;

                if (m_done) begin
                    m_done = 0;
                end else if (m_active) begin
                    if (mem_ack) begin
                        m_beat++;
                        if (m_beat == ROWS) begin m_active = 0; m_done = 1; end
                    end else begin
                        m_waits++;
                    end
                end else if (req_valid && (req_ls == 2'b01 || req_ls == 2'b10)) begin
                    m_base   = req_rs + 32'(int'($signed(req_imm)));
                    m_stride = req_stride;
                    m_rd     = req_rd;
                    m_store  = (req_ls == 2'b10);
                    m_beat   = 0;
                    m_waits  = 0;
                    m_acc    = cyc;
                    m_err    = 0;
`ifdef SP_LS_ALIGN_ERR_EN
                    if (m_base[2:0] != 3'b000 || m_stride[2:0] != 3'b000) begin
                        m_err = 1; m_done = 1;
                    end else begin
                        m_active = 1;
                    end
`else
                    m_active = 1;
`endif
                end
            end
        end
    end

    // Scratchpad responder: a programmable wait before each ack. It toggles
    // ack randomly while no beat is requested.
    initial begin
        mem_ack = 0; mem_rdata = '0;
        forever begin
            @(posedge CLK); #1;
            if (mem_req) begin
                if (wait_left == 0) begin
                    mem_ack   = 1;
                    mem_rdata = {$urandom, $urandom};
                    wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                end else begin
                    mem_ack = 0;
                    wait_left--;
                end
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    task automatic do_req(input logic [1:0] ls, input logic [4:0] rd, input logic [31:0] rs,
                          input logic [31:0] st, input logic [10:0] imm, input int wt, input bit hold);
        int n;
        @(posedge CLK); #1;
        fixed_wait = wt;
        wait_left  = (wt >= 0) ? wt : $urandom_range(0, 3);
        req_valid = 1; req_ls = ls; req_rd = rd; req_rs = rs; req_stride = st; req_imm = imm;
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!req_ready && n < 50);
        chk("accept_wait", req_ready, 1);
        @(posedge CLK); #1;
        if (hold) begin
            req_rd = ~rd; req_ls = 2'b01; req_rs = 32'h0;
            n = 0;
            while (!mhit && n < 200) begin @(negedge CLK); #1; n++; end
            chk("hold_mhit_seen", mhit, 1);
            chk("hold_ready_in_done", req_ready, 0);
            @(posedge CLK); #1;
        end
        req_valid = 0; req_ls = 2'($urandom); req_rs = $urandom; req_imm = 11'($urandom);
        n = 0;
        while ((m_active || m_done) && n < 200) begin @(negedge CLK); #1; n++; end
        chk("done_wait", m_active || m_done, 0);
    endtask

    task automatic clr_logs();
        addr_log.delete();
        row_log.delete();
    endtask

    logic [31:0] exp_a[4];
    int a0, m0, r0, e0, q0;
    logic [31:0] rs_r, st_r;
    logic [1:0]  ls_r;

    initial begin
        req_valid = 0; req_ls = 0; req_rd = 0; req_rs = 0; req_stride = 0; req_imm = 0;
        fixed_wait = 0; wait_left = 0;
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < ROWS; k++)
                rfm[r][k] = {$urandom, $urandom};
        repeat (3) @(posedge CLK);
        #1 RST = 0;

        // Zero-wait load: four rows, mhit 5 cycles after acceptance.
        clr_logs(); r0 = rfw_cnt;
        do_req(2'b01, 5'd7, 32'h1000, 32'h40, 11'h008, 0, 0);
        chk("ld_latency", last_mhit - last_acc, 5);
        chk("ld_nbeats", addr_log.size(), 4);
        exp_a = '{32'h1008, 32'h1048, 32'h1088, 32'h10C8};
        for (int i = 0; i < 4; i++)
            chk("ld_addr", (i < addr_log.size()) ? addr_log[i] : 32'hDEADBEEF, exp_a[i]);
        chk("ld_rf_wen_count", rfw_cnt - r0, 4);

        // Store, two wait cycles per beat: 4*3 + 1 = 13.
        clr_logs();
        do_req(2'b10, 5'd3, 32'h2000, 32'h80, 11'h000, 2, 0);
        chk("st_latency", last_mhit - last_acc, 13);
        for (int i = 0; i < 4; i++)
            chk("st_row_seq", (i < row_log.size()) ? row_log[i] : -1, i);
        chk("st_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEADBEEF, 32'h2080);

        // Negative offset and address wrap.
        clr_logs();
        do_req(2'b01, 5'd1, 32'h8, 32'h10, 11'h7F8, 0, 0);
        chk("neg_imm_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEADBEEF, 32'h0);
        clr_logs();
        do_req(2'b01, 5'd1, 32'h0, 32'h10, 11'h7F8, 0, 0);
        chk("wrap_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEADBEEF, 32'hFFFFFFF8);

        // Invalid ls codes are dropped.
        q0 = memreq_cnt; m0 = mhit_cnt;
        do_req(2'b00, 5'd2, 32'h100, 32'h8, 11'h0, 0, 0);
        do_req(2'b11, 5'd2, 32'h100, 32'h8, 11'h0, 0, 0);
        chk("inv_no_mem", memreq_cnt - q0, 0);
        chk("inv_no_mhit", mhit_cnt - m0, 0);

        // Back-pressure: valid stays high for the whole transfer.
        a0 = acc_cnt; m0 = mhit_cnt;
        do_req(2'b01, 5'd9, 32'h3000, 32'h8, 11'h0, 1, 1);
        chk("bp_accepts", acc_cnt - a0, 1);
        chk("bp_mhits", mhit_cnt - m0, 1);

        // Stride 0x44: either an alignment error or rounded-down addresses.
        clr_logs(); q0 = memreq_cnt; e0 = err_cnt;
        do_req(2'b01, 5'd2, 32'h1000, 32'h44, 11'h0, 0, 0);
`ifdef SP_LS_ALIGN_ERR_EN
        chk("al_no_mem", memreq_cnt - q0, 0);
        chk("al_err", err_cnt - e0, 1);
        chk("al_latency", last_mhit - last_acc, 1);
`else
        chk("al_err_none", err_cnt - e0, 0);
        exp_a = '{32'h1000, 32'h1040, 32'h1088, 32'h10C8};
        for (int i = 0; i < 4; i++)
            chk("al_masked_addr", (i < addr_log.size()) ? addr_log[i] : 32'hDEADBEEF, exp_a[i]);
`endif

        // Reset after two beats.
        r0 = rfw_cnt; m0 = mhit_cnt;
        @(posedge CLK); #1;
        fixed_wait = 0; wait_left = 0;
        req_valid = 1; req_ls = 2'b01; req_rd = 5'd4; req_rs = 32'h4000; req_stride = 32'h8; req_imm = 0;
        @(negedge CLK); #1;
        chk("rst_test_ready", req_ready, 1);
        @(posedge CLK); #1; req_valid = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1; RST = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        repeat (8) @(negedge CLK);
        #1;
        chk("rst_rf_wen_count", rfw_cnt - r0, 2);
        chk("rst_no_mhit", mhit_cnt - m0, 0);
        chk("rst_ready_after", req_ready, 1);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            ls_r = ($urandom_range(0, 9) < 8) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'($urandom);
            rs_r = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFF8);
            st_r = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFF8);
            do_req(ls_r, 5'($urandom), rs_r, st_r, 11'($urandom), -1, 0);
            repeat ($urandom_range(0, 3)) @(posedge CLK);
        end

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sp_matrix_ls_resp.md
SP_MATRIX_LS_RESP -- requirements
Module: sp_matrix_ls_resp

Interface
REQ-001 SHALL have parameter ROWS, default 4: matrix rows transferred per request.
REQ-002 SHALL have parameter ROW_W, default 64: bits per matrix row and per memory beat.
REQ-003 SHALL have ports CLK input 1 (single clock) and RST input 1 (asynchronous, active-high reset).
REQ-004 SHALL have port req_valid input 1: matrix load/store request from the matrix LS functional unit.
REQ-005 SHALL have port req_ls input 2: 2'b01 load, 2'b10 store, other values invalid.
REQ-006 SHALL have ports req_rd input 5 (matrix register), req_rs input 32 (base), req_stride input 32 (bytes between rows), req_imm input 11 (signed offset).
REQ-007 SHALL have port req_ready output 1: request accepted when req_valid and req_ready are both high on a CLK edge.
REQ-008 SHALL have ports mem_req output 1, mem_wen output 1, mem_addr output 32, mem_wdata output ROW_W, mem_rdata input ROW_W and mem_ack input 1 (scratchpad beat port).
REQ-009 SHALL have ports rf_wen output 1, rf_waddr output 5, rf_row output $clog2(ROWS) and rf_wdata output ROW_W (matrix register file row write).
REQ-010 SHALL have ports st_raddr output 5, st_row output $clog2(ROWS) and st_rdata input ROW_W (combinational register file row read for stores).
REQ-011 SHALL have ports mhit output 1 (one-cycle completion pulse, consumed by the FU), err output 1 and busy output 1.

Function
REQ-012 SHALL implement FSM states IDLE, XFER and DONE.
REQ-013 SHALL hold req_ready high only in IDLE.
REQ-014 SHALL, in IDLE, on acceptance with a valid req_ls, latch rd, ls and stride, compute base = req_rs + sign-extended req_imm (mod 2^32), clear the row counter and go to XFER.
REQ-015 SHALL accept a request with invalid req_ls (00/11) and drop it: stay in IDLE, no memory access, no mhit.
REQ-016 SHALL, in XFER, drive mem_req=1 with mem_addr = base + row*stride (mod 2^32), holding addr, wen and wdata stable until mem_ack.
REQ-017 SHALL drive mem_wen=1 and mem_wdata=st_rdata on stores, with st_raddr=latched rd and st_row=row counter; mem_wen SHALL be 0 on loads.
REQ-018 SHALL, on load, pulse rf_wen in the mem_ack cycle, with rf_waddr=rd, rf_row=row counter and rf_wdata=mem_rdata.
REQ-019 SHALL accept mem_ack in the same cycle mem_req rises (zero-wait memory), and SHALL ignore mem_ack while mem_req is low.
REQ-020 SHALL increment the row counter on each acked beat and go to DONE after the beat for row ROWS-1.
REQ-021 SHALL, in DONE, assert mhit for exactly one cycle, then return to IDLE.
REQ-022 SHALL make zero-wait latency ROWS+1 cycles from acceptance to mhit; each wait cycle on mem_ack SHALL add one cycle.
REQ-023 SHALL hold busy high in XFER and DONE.
REQ-024 SHALL ignore req_valid while not in IDLE.

Reset
REQ-025 SHALL, while RST is high, force IDLE, row counter 0, and mem_req, mem_wen, rf_wen, mhit, err and busy to 0, with mem_addr, mem_wdata, rf_waddr, rf_row and rf_wdata at 0 and req_ready at 1.
REQ-026 SHALL, when RST is asserted mid-transfer, abandon the transfer with no further rf_wen and no mhit.

Configuration
REQ-027 SHALL, with SP_LS_ALIGN_ERR_EN defined, check alignment: if base[2:0]!=0 or stride[2:0]!=0, go straight to DONE with no memory beats, and assert err together with mhit for that one cycle.
REQ-028 SHALL, with SP_LS_ALIGN_ERR_EN undefined, force mem_addr[2:0] to 0 and tie err to 0.

Verification
REQ-029 Load: rs=0x1000, imm=0x008, stride=0x40, zero-wait -> addrs 0x1008/0x1048/0x1088/0x10C8, four rf_wen with rows 0-3, mhit on cycle 5.
REQ-030 Store: rd=3, mem_ack delayed 2 cycles per beat -> mem_wen=1, addr held stable, st_row 0..3, mhit on cycle 13.
REQ-031 Negative imm: imm=0x7F8 (-8), rs=0x8 -> first mem_addr 0x0; with rs=0x0 -> first mem_addr 0xFFFFFFF8 (wrap).
REQ-032 Back-pressure: second req_valid during busy is ignored; req_ready=0 until the cycle after mhit.
REQ-033 Reset after beat 2 -> no further rf_wen, mhit stays 0, req_ready=1.
REQ-034 SP_LS_ALIGN_ERR_EN defined, stride=0x44 -> no mem_req, mhit=1 and err=1 one cycle after acceptance.
